// File: rtl/alu_pkg.sv
// Shared definitions for the decode/issue stage and the ALU: opcodes,
// 12-bit ALU op codes and the issue bundle.
package alu_pkg;
  localparam int DATA_W = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // {b11, b10, funct3, opcode}
  localparam logic [11:0] ALU_ADD  = 12'b000000110011;
  localparam logic [11:0] ALU_SUB  = 12'b100000110011;
  localparam logic [11:0] ALU_SRLI = 12'b001010010011;
  localparam logic [11:0] ALU_SRAI = 12'b011010010011;
  localparam logic [11:0] ALU_BEQ  = 12'b000001100011;
  localparam logic [11:0] ALU_JAL  = 12'b000001101111;
  localparam logic [11:0] ALU_LUI  = 12'b000000110111;

  typedef struct packed {
    logic [11:0]       operation;
    logic [DATA_W-1:0] opr1;
    logic [DATA_W-1:0] opr2;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] store_data;
    logic [4:0]        rd;
    logic              rd_we;
    logic              illegal;
  } issue_t;
endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode: instruction word plus register read data
// into one ALU issue bundle.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  output issue_t            bundle
);
  logic [6:0]        opc;
  logic [2:0]        f3;
  logic              writes;
  logic [DATA_W-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, shamt;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign imm_i = {{(DATA_W-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(DATA_W-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{(DATA_W-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{(DATA_W-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {{(DATA_W-32){instr[31]}}, instr[31:12], 12'b0};
  assign shamt = {{(DATA_W-5){1'b0}}, instr[24:20]};

  always_comb begin
    bundle      = '0;
    writes      = 1'b0;
    bundle.pc   = pc;
    bundle.rd   = instr[11:7];
    bundle.opr1 = rs1_data;
    case (opc)
      OPC_OP: begin
        bundle.operation = {instr[30], 1'b0, f3, opc};
        bundle.opr2      = rs2_data;
        writes           = 1'b1;
      end
      OPC_OP_IMM: begin
        // only srli/srai carry the arithmetic bit; slli/srli/srai use shamt
        bundle.operation = {1'b0, (f3 == 3'b101) ? instr[30] : 1'b0, f3, opc};
        bundle.opr2      = (f3 == 3'b001 || f3 == 3'b101) ? shamt : imm_i;
        writes           = 1'b1;
      end
      OPC_LOAD: begin
        bundle.operation = {2'b00, f3, opc};
        bundle.opr2      = imm_i;
        writes           = 1'b1;
      end
      OPC_STORE: begin
        bundle.operation  = {2'b00, f3, opc};
        bundle.opr2       = imm_s;
        bundle.store_data = rs2_data;
      end
      OPC_BRANCH: begin
        bundle.operation = {2'b00, f3, opc};
        bundle.opr2      = rs2_data;
        bundle.imm       = imm_b;
      end
      OPC_JAL: begin
        bundle.operation = {5'b0, opc};
        bundle.opr1      = '0;
        bundle.imm       = imm_j;
        writes           = 1'b1;
      end
      OPC_JALR: begin
        bundle.operation = {2'b00, f3, opc};
        bundle.opr2      = imm_i;
        bundle.imm       = imm_i;
        writes           = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        bundle.operation = {5'b0, opc};
        bundle.opr1      = '0;
        bundle.opr2      = imm_u;
        writes           = 1'b1;
      end
      default: bundle.illegal = 1'b1;
    endcase
    bundle.rd_we = writes && (instr[11:7] != 5'd0);
  end
endmodule

// File: rtl/alu_issue.sv
// Decode/issue stage: valid/ready input, 2-entry (main + skid) output
// buffer feeding the ALU, flushable on a taken redirect.
module alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN = DATA_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [11:0]     operation,
  output logic [XLEN-1:0] opr1,
  output logic [XLEN-1:0] opr2,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            illegal
);
  issue_t dec, main_q, skid_q;
  logic   main_valid, skid_valid;
  logic   accept, main_free;

  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  alu_issue_decode u_dec (
    .instr    (in_instr),
    .pc       (in_pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .bundle   (dec)
  );

  // in_ready depends only on registered state, never on out_ready
  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready && !flush;
  assign main_free = !main_valid || out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      // skid is older than anything arriving now (and blocks accept anyway)
      if (skid_valid) main_q <= skid_q;
      else if (accept) main_q <= dec;
      main_valid <= skid_valid || accept;
      skid_valid <= 1'b0;
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid  = main_valid;
  assign operation  = main_q.operation;
  assign opr1       = main_q.opr1;
  assign opr2       = main_q.opr2;
  assign pc_out     = main_q.pc;
  assign imm        = main_q.imm;
  assign store_data = main_q.store_data;
  assign rd         = main_q.rd;
  assign rd_we      = main_q.rd_we;
  assign illegal    = main_q.illegal;
endmodule

// File: tb/tb_alu_issue.sv
// Randomized + directed bench for alu_issue against a queue-based
// reference model of the issue buffer and an ISA-level decode model.
module tb_alu_issue;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0, rs1_data = '0, rs2_data = '0;
  logic        in_ready, out_valid, rd_we, illegal;
  logic [4:0]  rs1_addr, rs2_addr, rd;
  logic [11:0] operation;
  logic [31:0] opr1, opr2, pc_out, imm, store_data;

  always #5 clk = ~clk;

  alu_issue #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .operation(operation),
    .opr1(opr1), .opr2(opr2), .pc_out(pc_out), .imm(imm),
    .store_data(store_data), .rd(rd), .rd_we(rd_we), .illegal(illegal)
  );

  typedef struct {
    logic [11:0] op;
    logic [31:0] o1, o2, pc, imm, sd;
    logic [4:0]  rd;
    logic        we, ill;
  } bun_t;

  bun_t q[$];
  int   n_chk = 0, n_err = 0, n_issued = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bun_t ref_dec(input logic [31:0] w, input logic [31:0] p, r1, r2);
    bun_t b;
    logic [2:0]  f3 = w[14:12];
    logic [31:0] ii = 32'($signed(w[31:20]));
    logic [31:0] is = 32'($signed({w[31:25], w[11:7]}));
    logic [31:0] ib = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
    logic [31:0] ij = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
    logic        wr = 1'b1;
    b = '{op: 12'd0, o1: r1, o2: 32'd0, pc: p, imm: 32'd0, sd: 32'd0,
          rd: w[11:7], we: 1'b0, ill: 1'b0};
    case (w[6:0])
      7'b0110011: begin b.op = {w[30], 1'b0, f3, w[6:0]}; b.o2 = r2; end
      7'b0010011: begin
        b.op = {1'b0, (f3 == 3'd5) ? w[30] : 1'b0, f3, w[6:0]};
        b.o2 = (f3 == 3'd1 || f3 == 3'd5) ? 32'(w[24:20]) : ii;
      end
      7'b0000011: begin b.op = {2'b0, f3, w[6:0]}; b.o2 = ii; end
      7'b0100011: begin b.op = {2'b0, f3, w[6:0]}; b.o2 = is; b.sd = r2; wr = 1'b0; end
      7'b1100011: begin b.op = {2'b0, f3, w[6:0]}; b.o2 = r2; b.imm = ib; wr = 1'b0; end
      7'b1101111: begin b.op = {5'b0, w[6:0]}; b.o1 = 0; b.imm = ij; end
      7'b1100111: begin b.op = {2'b0, f3, w[6:0]}; b.o2 = ii; b.imm = ii; end
      7'b0110111, 7'b0010111: begin b.op = {5'b0, w[6:0]}; b.o1 = 0; b.o2 = {w[31:12], 12'b0}; end
      default: begin b.ill = 1'b1; wr = 1'b0; end
    endcase
    b.we = wr && (w[11:7] != 0);
    return b;
  endfunction

  task automatic check_outputs();
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    if (q.size() > 0) begin
      chk("operation", operation, q[0].op);
      chk("opr1", opr1, q[0].o1);
      chk("opr2", opr2, q[0].o2);
      chk("pc_out", pc_out, q[0].pc);
      chk("imm", imm, q[0].imm);
      chk("store_data", store_data, q[0].sd);
      chk("rd", rd, q[0].rd);
      chk("rd_we", rd_we, q[0].we);
      chk("illegal", illegal, q[0].ill);
    end
  endtask

  // One clock: drive at negedge, check mid-cycle, advance model at posedge.
  task automatic cycle(input logic iv, input logic [31:0] w, p, r1, r2,
                       input logic fl, input logic ordy);
    bun_t b;
    logic acc, drn;
    @(negedge clk);
    in_valid = iv; in_instr = w; in_pc = p; rs1_data = r1; rs2_data = r2;
    flush = fl; out_ready = ordy;
    #1;
    check_outputs();
    chk("rs1_addr", rs1_addr, w[19:15]);
    chk("rs2_addr", rs2_addr, w[24:20]);
    b   = ref_dec(w, p, r1, r2);
    acc = iv && (q.size() < 2) && !fl;
    drn = (q.size() > 0) && ordy;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (drn) begin void'(q.pop_front()); n_issued++; end
      if (acc) q.push_back(b);
    end
    #2;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111};
    logic [31:0] w = $urandom;
    w[6:0] = ops[$urandom_range(0, 9)];
    return w;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  logic [31:0] stream [4];
  int          idx, base;
  logic        pre_rdy;

  initial begin
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_operation", operation, 0);
    chk("rst_opr2", opr2, 0);
    @(negedge clk); reset = 1'b0;

    // add x3,x1,x2
    cycle(1, {7'b0, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011}, 32'h40, 5, 7, 0, 1);
    chk("add_op", operation, 12'b000000110011);
    chk("add_opr1", opr1, 5);
    chk("add_opr2", opr2, 7);
    chk("add_rd", rd, 3);
    chk("add_we", rd_we, 1);

    // srai x5,x6,4 then sw x2,-8(x1)
    cycle(1, {7'b0100000, 5'd4, 5'd6, 3'd5, 5'd5, 7'b0010011}, 32'h44, 32'h80000000, 9, 0, 1);
    chk("srai_op", operation, 12'b011010010011);
    chk("srai_opr2", opr2, 4);
    cycle(1, {7'h7F, 5'd2, 5'd1, 3'd2, 5'h18, 7'b0100011}, 32'h48, 32'h1000, 32'hCAFE, 0, 1);
    chk("sw_opr2", opr2, 32'hFFFFFFF8);
    chk("sw_sd", store_data, 32'hCAFE);
    chk("sw_we", rd_we, 0);
    idle(1);

    // stream of 4 with a 2-cycle stall after the first issues
    for (int i = 0; i < 4; i++) stream[i] = rand_instr();
    idx = 0; base = n_issued;
    for (int c = 0; c < 20 && (idx < 4 || q.size() > 0); c++) begin
      pre_rdy = q.size() < 2;
      cycle(idx < 4, stream[idx % 4], 32'h200 + 4 * idx, $urandom, $urandom, 0,
            !(c == 1 || c == 2));
      if (idx < 4 && pre_rdy) idx++;
      if (c == 1) chk("stall_in_ready", in_ready, 0);
    end
    chk("stream_issued", n_issued - base, 4);

    // fill buffer, then flush with a valid input
    cycle(1, rand_instr(), 32'h300, $urandom, $urandom, 0, 0);
    cycle(1, rand_instr(), 32'h304, $urandom, $urandom, 0, 0);
    chk("full_in_ready", in_ready, 0);
    cycle(1, rand_instr(), 32'h308, $urandom, $urandom, 1, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    idle(3);

    // illegal opcode, then reset while stalled
    cycle(1, 32'h0000_018F, 32'h400, 1, 2, 0, 0);
    chk("ill_flag", illegal, 1);
    chk("ill_op", operation, 0);
    chk("ill_we", rd_we, 0);
    cycle(1, {7'b0, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011}, 32'h404, 1, 2, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_opr1", opr1, 0);
    chk("mid_rst_pc", pc_out, 0);
    chk("mid_rst_illegal", illegal, 0);
    q.delete();
    @(negedge clk); reset = 1'b0;

    // jal x1,+16 at 0x100 ; lui x4,0x12345
    cycle(1, {1'b0, 10'd8, 1'b0, 8'd0, 5'd1, 7'b1101111}, 32'h100, 3, 4, 0, 1);
    chk("jal_op", operation, 12'b000001101111);
    chk("jal_imm", imm, 16);
    chk("jal_pc", pc_out, 32'h100);
    chk("jal_we", rd_we, 1);
    cycle(1, {20'h12345, 5'd4, 7'b0110111}, 32'h104, 3, 4, 0, 1);
    chk("lui_opr2", opr2, 32'h12345000);

    for (int i = 0; i < 500; i++)
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom,
            $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
